// File: rtl/output_serializer.sv
// rtl/output_serializer.sv - captures a multi-word core result and returns it as bus-width beats
// Per-beat OutBuffFull/ReceiveData handshake; DataOut is released whenever no beat is held.
module output_serializer #(
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 2,
  parameter int BUS_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit TRISTATE  = 1'b1,
  localparam int TOT_W    = DATA_W * NUM_WORDS,
  localparam int NBEATS   = TOT_W / BUS_W,
  localparam int CNT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             Ready,
  input  logic [TOT_W-1:0] data_in,
  input  logic             ReceiveData,
  output logic             ReadyForInput,
  output logic             OutBuffFull,
  output logic [BUS_W-1:0] DataOut,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             last_beat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUS_W-1:0]   beats [NBEATS];
  logic [BUS_W-1:0]   beat;
  logic               send;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    // clear outranks every other input; the held buffer is deliberately kept
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!Ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (Ready) begin
            buf_d   = data_in;
            cnt_d   = '0;
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (ReceiveData) begin
            if (cnt_q == LAST_CNT) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NBEATS; k++) begin
      if (MSB_FIRST) beats[k] = buf_q[TOT_W-1-k*BUS_W -: BUS_W];
      else           beats[k] = buf_q[k*BUS_W +: BUS_W];
    end
  end

  assign beat          = beats[cnt_q];
  assign send          = (state_q == ST_SEND);
  assign ReadyForInput = (state_q == ST_IDLE);
  assign OutBuffFull   = send;
  assign beat_cnt      = cnt_q;
  assign last_beat     = send && (cnt_q == LAST_CNT);

  // Output enable follows state_q directly, so an async reset releases the bus at once
  generate
    if (TRISTATE) begin : g_tri
      assign DataOut = send ? beat : {BUS_W{1'bz}};
    end else begin : g_zero
      assign DataOut = send ? beat : {BUS_W{1'b0}};
    end
  endgenerate

endmodule

// File: tb/tb_output_serializer.sv
// tb/tb_output_serializer.sv - randomized self-checking bench for output_serializer
// Three instances: defaults on a shared bus, LSB-first without tri-state, and 12-bit words.
module tb_output_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        ready = 1'b1;
  logic        rd = 1'b0;
  logic        probe_en = 1'b0;
  logic [31:0] din = 32'h0;

  wire  [7:0]  bus_a;
  logic        rfi_a, obf_a, last_a;
  logic [1:0]  cnt_a;
  logic        rfi_b, obf_b, last_b;
  logic [1:0]  cnt_b;
  logic [7:0]  do_b;
  logic        rfi_c, obf_c, last_c;
  logic [1:0]  cnt_c;
  wire  [7:0]  do_c;

  int n_checks = 0;
  int n_fail = 0;

  // A second bus agent: reads 5A only when the serializer has released the bus
  assign bus_a = probe_en ? 8'h5A : 8'hzz;

  always #5 clk = ~clk;

  output_serializer u_a (
    .clk(clk), .reset(reset), .clear(clear), .Ready(ready), .data_in(din),
    .ReceiveData(rd), .ReadyForInput(rfi_a), .OutBuffFull(obf_a),
    .DataOut(bus_a), .beat_cnt(cnt_a), .last_beat(last_a)
  );

  output_serializer #(.MSB_FIRST(1'b0), .TRISTATE(1'b0)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .Ready(ready), .data_in(din),
    .ReceiveData(rd), .ReadyForInput(rfi_b), .OutBuffFull(obf_b),
    .DataOut(do_b), .beat_cnt(cnt_b), .last_beat(last_b)
  );

  output_serializer #(.DATA_W(12)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .Ready(ready), .data_in(din[23:0]),
    .ReceiveData(rd), .ReadyForInput(rfi_c), .OutBuffFull(obf_c),
    .DataOut(do_c), .beat_cnt(cnt_c), .last_beat(last_c)
  );

  function automatic logic [7:0] exp_beat(input logic [31:0] data, input int nb,
                                          input bit msb, input int k);
    int pos;
    pos = msb ? (nb - 1 - k) : k;
    return 8'((data >> (pos * 8)) & 32'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_transfer(input logic [31:0] data);
    ready = 1'b0;
    tick();
    din = data;
    ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (rfi_a !== 1'b1) begin n_fail++; $display("FAIL reset_rfi: got %b expected 1", rfi_a); end
    n_checks++; if (obf_a !== 1'b0) begin n_fail++; $display("FAIL reset_obf: got %b expected 0", obf_a); end
    n_checks++; if (cnt_a !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
    n_checks++; if (last_a !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", last_a); end
    n_checks++; if (do_b !== 8'h00) begin n_fail++; $display("FAIL reset_b_zero: got %h expected 00", do_b); end
    probe_en = 1'b1; #1;
    n_checks++; if (bus_a !== 8'h5A) begin n_fail++; $display("FAIL reset_bus_release: got %h expected 5a", bus_a); end
    probe_en = 1'b0;
  endtask

  task automatic test_defaults();
    logic [7:0] exp_a [4];
    exp_a = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    din = 32'hDEAD_BEEF;
    rd = 1'b1;
    ready = 1'b0;
    tick();
    n_checks++; if (rfi_a !== 1'b0 || obf_a !== 1'b0) begin n_fail++; $display("FAIL wait_status: got rfi=%b obf=%b expected 0 0", rfi_a, obf_a); end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (bus_a !== exp_a[k]) begin n_fail++; $display("FAIL msb_beat%0d: got %h expected %h", k, bus_a, exp_a[k]); end
      n_checks++; if (cnt_a !== 2'(k) || obf_a !== 1'b1) begin n_fail++; $display("FAIL msb_cnt%0d: got cnt=%0d obf=%b expected %0d 1", k, cnt_a, obf_a, k); end
      n_checks++; if (last_a !== (k == 3)) begin n_fail++; $display("FAIL msb_last%0d: got %b expected %b", k, last_a, k == 3); end
      n_checks++; if (do_b !== exp_a[3-k] || cnt_b !== 2'(k)) begin n_fail++; $display("FAIL lsb_beat%0d: got %h cnt=%0d expected %h cnt=%0d", k, do_b, cnt_b, exp_a[3-k], k); end
    end
    tick();
    n_checks++; if (rfi_a !== 1'b1 || obf_a !== 1'b0) begin n_fail++; $display("FAIL defaults_idle: got rfi=%b obf=%b expected 1 0", rfi_a, obf_a); end
    n_checks++; if (rfi_b !== 1'b1 || do_b !== 8'h00) begin n_fail++; $display("FAIL defaults_idle_b: got rfi=%b do=%h expected 1 00", rfi_b, do_b); end
    rd = 1'b0;
  endtask

  task automatic test_stall();
    rd = 1'b1;
    start_transfer(32'hDEAD_BEEF);
    tick();
    n_checks++; if (bus_a !== 8'hAD || cnt_a !== 2'd1) begin n_fail++; $display("FAIL stall_enter: got %h cnt=%0d expected ad 1", bus_a, cnt_a); end
    rd = 1'b0;
    din = 32'h0;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus_a !== 8'hAD || cnt_a !== 2'd1 || obf_a !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: got %h cnt=%0d obf=%b expected ad 1 1", i, bus_a, cnt_a, obf_a); end
      n_checks++; if (do_b !== 8'hBE) begin n_fail++; $display("FAIL stall_hold_b%0d: got %h expected be", i, do_b); end
    end
    ready = 1'b1;
    rd = 1'b1;
    tick();
    n_checks++; if (bus_a !== 8'hBE || cnt_a !== 2'd2) begin n_fail++; $display("FAIL stall_resume2: got %h cnt=%0d expected be 2", bus_a, cnt_a); end
    tick();
    n_checks++; if (bus_a !== 8'hEF || last_a !== 1'b1) begin n_fail++; $display("FAIL stall_resume3: got %h last=%b expected ef 1", bus_a, last_a); end
    tick();
    n_checks++; if (rfi_a !== 1'b1) begin n_fail++; $display("FAIL stall_idle: got %b expected 1", rfi_a); end
    rd = 1'b0;
  endtask

  task automatic test_width12();
    logic [7:0] exp_c [3];
    exp_c = '{8'hAB, 8'hC1, 8'h23};
    rd = 1'b1;
    start_transfer(32'h00AB_C123);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (do_c !== exp_c[k] || cnt_c !== 2'(k)) begin n_fail++; $display("FAIL w12_beat%0d: got %h cnt=%0d expected %h %0d", k, do_c, cnt_c, exp_c[k], k); end
      n_checks++; if (last_c !== (k == 2)) begin n_fail++; $display("FAIL w12_last%0d: got %b expected %b", k, last_c, k == 2); end
      tick();
    end
    n_checks++; if (rfi_c !== 1'b1 || obf_c !== 1'b0) begin n_fail++; $display("FAIL w12_idle: got rfi=%b obf=%b expected 1 0", rfi_c, obf_c); end
    tick();
    n_checks++; if (rfi_a !== 1'b1) begin n_fail++; $display("FAIL w12_a_idle: got %b expected 1", rfi_a); end
    rd = 1'b0;
  endtask

  task automatic test_abort();
    rd = 1'b1;
    start_transfer(32'hDEAD_BEEF);
    repeat (2) tick();
    n_checks++; if (cnt_a !== 2'd2 || bus_a !== 8'hBE) begin n_fail++; $display("FAIL abort_pre: got %h cnt=%0d expected be 2", bus_a, cnt_a); end
    reset = 1'b1;
    #1;
    n_checks++; if (obf_a !== 1'b0 || cnt_a !== 2'd0) begin n_fail++; $display("FAIL abort_reset: got obf=%b cnt=%0d expected 0 0", obf_a, cnt_a); end
    probe_en = 1'b1; #1;
    n_checks++; if (bus_a !== 8'h5A) begin n_fail++; $display("FAIL abort_bus_release: got %h expected 5a", bus_a); end
    probe_en = 1'b0;
    tick();
    reset = 1'b0;
    start_transfer(32'h1234_5678);
    tick();
    n_checks++; if (cnt_a !== 2'd1 || bus_a !== 8'h34) begin n_fail++; $display("FAIL clear_pre: got %h cnt=%0d expected 34 1", bus_a, cnt_a); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (rfi_a !== 1'b1 || obf_a !== 1'b0 || cnt_a !== 2'd0) begin n_fail++; $display("FAIL clear_idle: got rfi=%b obf=%b cnt=%0d expected 1 0 0", rfi_a, obf_a, cnt_a); end
    n_checks++; if (rfi_b !== 1'b1 || do_b !== 8'h00) begin n_fail++; $display("FAIL clear_idle_b: got rfi=%b do=%h expected 1 00", rfi_b, do_b); end
    tick();
    n_checks++; if (rfi_a !== 1'b1 || cnt_a !== 2'd0) begin n_fail++; $display("FAIL clear_stay: got rfi=%b cnt=%0d expected 1 0", rfi_a, cnt_a); end
    rd = 1'b0;
  endtask

  task automatic test_idle();
    ready = 1'b1;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks++; if (rfi_a !== 1'b1 || obf_a !== 1'b0 || cnt_a !== 2'd0) begin n_fail++; $display("FAIL idle_rd: got rfi=%b obf=%b cnt=%0d expected 1 0 0", rfi_a, obf_a, cnt_a); end
    n_checks++; if (do_b !== 8'h00) begin n_fail++; $display("FAIL idle_b_zero: got %h expected 00", do_b); end
    probe_en = 1'b1; #1;
    n_checks++; if (bus_a !== 8'h5A) begin n_fail++; $display("FAIL idle_bus: got %h expected 5a", bus_a); end
    probe_en = 1'b0;
    ready = 1'b0;
    tick();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks++; if (rfi_a !== 1'b0 || obf_a !== 1'b0 || cnt_a !== 2'd0 || last_a !== 1'b0) begin n_fail++; $display("FAIL wait_rd: got rfi=%b obf=%b cnt=%0d last=%b expected 0 0 0 0", rfi_a, obf_a, cnt_a, last_a); end
    n_checks++; if (do_b !== 8'h00) begin n_fail++; $display("FAIL wait_b_zero: got %h expected 00", do_b); end
    probe_en = 1'b1; #1;
    n_checks++; if (bus_a !== 8'h5A) begin n_fail++; $display("FAIL wait_bus: got %h expected 5a", bus_a); end
    probe_en = 1'b0;
    clear = 1'b1;
    ready = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (rfi_a !== 1'b1) begin n_fail++; $display("FAIL wait_clear: got %b expected 1", rfi_a); end
  endtask

  task automatic test_random();
    int ia, ib, ic, guard;
    logic [31:0] data;
    for (int t = 0; t < 40; t++) begin
      data = $urandom;
      start_transfer(data);
      ia = 0; ib = 0; ic = 0; guard = 0;
      forever begin
        if (ia < 4) begin
          n_checks++; if (bus_a !== exp_beat(data, 4, 1'b1, ia) || cnt_a !== 2'(ia) || last_a !== (ia == 3)) begin n_fail++; $display("FAIL rnd_a t%0d: got %h cnt=%0d last=%b expected %h %0d", t, bus_a, cnt_a, last_a, exp_beat(data, 4, 1'b1, ia), ia); end
        end else begin
          n_checks++; if (rfi_a !== 1'b1 || obf_a !== 1'b0) begin n_fail++; $display("FAIL rnd_a_idle t%0d: got rfi=%b obf=%b expected 1 0", t, rfi_a, obf_a); end
        end
        if (ib < 4) begin
          n_checks++; if (do_b !== exp_beat(data, 4, 1'b0, ib) || cnt_b !== 2'(ib)) begin n_fail++; $display("FAIL rnd_b t%0d: got %h cnt=%0d expected %h %0d", t, do_b, cnt_b, exp_beat(data, 4, 1'b0, ib), ib); end
        end else begin
          n_checks++; if (rfi_b !== 1'b1 || do_b !== 8'h00) begin n_fail++; $display("FAIL rnd_b_idle t%0d: got rfi=%b do=%h expected 1 00", t, rfi_b, do_b); end
        end
        if (ic < 3) begin
          n_checks++; if (do_c !== exp_beat(data & 32'h00FF_FFFF, 3, 1'b1, ic) || cnt_c !== 2'(ic) || last_c !== (ic == 2)) begin n_fail++; $display("FAIL rnd_c t%0d: got %h cnt=%0d last=%b expected %h %0d", t, do_c, cnt_c, last_c, exp_beat(data & 32'h00FF_FFFF, 3, 1'b1, ic), ic); end
        end else begin
          n_checks++; if (rfi_c !== 1'b1) begin n_fail++; $display("FAIL rnd_c_idle t%0d: got %b expected 1", t, rfi_c); end
        end
        if (ia == 4 && ib == 4 && ic == 3) break;
        guard++;
        if (guard > 100) begin
          n_checks++; n_fail++;
          $display("FAIL rnd_timeout t%0d: transfer did not complete within 100 cycles", t);
          break;
        end
        rd = 1'($urandom_range(0, 1));
        din = $urandom;
        tick();
        if (rd) begin
          if (ia < 4) ia++;
          if (ib < 4) ib++;
          if (ic < 3) ic++;
        end
      end
      rd = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_stall();
    test_width12();
    test_abort();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
